// File: rtl/sbox_share_sched_if.sv
// sbox_share_sched_if
//   Bundles the two requester channels, the external S-box link and the
//   scheduler status outputs into one interface.
//   Signals:
//     st_req/st_in/st_ack/st_out : state channel (128-bit block)
//     kw_req/kw_in/kw_ack/kw_out : key-word channel (32-bit word)
//     sb_byte/sb_sub             : byte to / substituted byte from the S-box
//     busy/grant                 : scheduler status
//   Modports:
//     slave  : the scheduler side
//     master : the requester / S-box side
interface sbox_share_sched_if;
  logic         st_req;
  logic [127:0] st_in;
  logic         st_ack;
  logic [127:0] st_out;
  logic         kw_req;
  logic [31:0]  kw_in;
  logic         kw_ack;
  logic [31:0]  kw_out;
  logic [7:0]   sb_byte;
  logic [7:0]   sb_sub;
  logic         busy;
  logic [1:0]   grant;

  modport slave (
    input  st_req, st_in, kw_req, kw_in, sb_sub,
    output st_ack, st_out, kw_ack, kw_out, sb_byte, busy, grant
  );

  modport master (
    output st_req, st_in, kw_req, kw_in, sb_sub,
    input  st_ack, st_out, kw_ack, kw_out, sb_byte, busy, grant
  );
endinterface

// File: rtl/sbox_share_sched.sv
// sbox_share_sched
//   Time-shares one external combinational byte S-box between the round
//   datapath (16-byte SubBytes blocks) and the key expansion (4-byte
//   SubWord words). Round-robin arbitration on ties, operand capture on the
//   grant edge, LSB-first byte serialisation, result reassembly and a
//   one-cycle ack per completed operation.
//   Ports:
//     clk  : system clock, rising edge
//     rst  : asynchronous active-low reset
//     bus  : sbox_share_sched_if.slave (channels, S-box link, busy/grant)
//     err  : sticky handshake-violation flag (only with SCHED_PROTO_CHK_EN)
//   Parameter:
//     KEY_FIRST : round-robin pointer after reset (1 = key wins first tie)
//   Optional build macro:
//     SCHED_PROTO_CHK_EN : adds the err output and its protocol checker.
module sbox_share_sched #(
  parameter bit KEY_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  sbox_share_sched_if.slave      bus
`ifdef SCHED_PROTO_CHK_EN
  ,
  output logic                   err
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN_ST = 2'd1,
    RUN_KW = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         rr_q, rr_d;        // 1: key channel wins the next tie
  logic         owner_q, owner_d;  // 1: key channel owns the S-box
  logic [127:0] shift_q, shift_d;
  logic [127:0] res_q, res_d;
  logic [127:0] st_out_q, st_out_d;
  logic [31:0]  kw_out_q, kw_out_d;

  logic         running;
  logic         last_byte;
  logic         pick_kw;
  logic [127:0] res_merged;

  assign running   = (state_q == RUN_ST) || (state_q == RUN_KW);
  assign last_byte = ((state_q == RUN_ST) && (cnt_q == 4'd15)) ||
                     ((state_q == RUN_KW) && (cnt_q == 4'd3));
  // Key wins when it is the only requester, or on a tie when the pointer says so.
  assign pick_kw   = bus.kw_req && (!bus.st_req || rr_q);

  always_comb begin
    res_merged = res_q;
    res_merged[{cnt_q, 3'b000} +: 8] = bus.sb_sub;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_d     = rr_q;
    owner_d  = owner_q;
    shift_d  = shift_q;
    res_d    = res_q;
    st_out_d = st_out_q;
    kw_out_d = kw_out_q;

    case (state_q)
      IDLE: begin
        if (bus.st_req || bus.kw_req) begin
          owner_d = pick_kw;
          cnt_d   = 4'd0;
          res_d   = '0;
          if (bus.st_req && bus.kw_req) begin
            rr_d = !pick_kw;
          end
          if (pick_kw) begin
            shift_d = {96'h0, bus.kw_in};
            state_d = RUN_KW;
          end else begin
            shift_d = bus.st_in;
            state_d = RUN_ST;
          end
        end
      end
      RUN_ST, RUN_KW: begin
        res_d   = res_merged;
        shift_d = {8'h00, shift_q[127:8]};
        cnt_d   = cnt_q + 4'd1;
        if (last_byte) begin
          // Publish on the edge into DONE so the output is valid with the ack.
          if (state_q == RUN_ST) begin
            st_out_d = res_merged;
          end else begin
            kw_out_d = res_merged[31:0];
          end
          state_d = DONE;
        end
      end
      DONE: begin
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      rr_q     <= KEY_FIRST;
      owner_q  <= 1'b0;
      shift_q  <= '0;
      res_q    <= '0;
      st_out_q <= '0;
      kw_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      owner_q  <= owner_d;
      shift_q  <= shift_d;
      res_q    <= res_d;
      st_out_q <= st_out_d;
      kw_out_q <= kw_out_d;
    end
  end

  assign bus.sb_byte = running ? shift_q[7:0] : 8'h00;
  assign bus.busy    = (state_q != IDLE);
  assign bus.grant   = (state_q == IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
  assign bus.st_ack  = (state_q == DONE) && !owner_q;
  assign bus.kw_ack  = (state_q == DONE) && owner_q;
  assign bus.st_out  = st_out_q;
  assign bus.kw_out  = kw_out_q;

`ifdef SCHED_PROTO_CHK_EN
  logic err_q, err_d;
  logic st_ack_prev_q, st_ack_prev_d;
  logic kw_ack_prev_q, kw_ack_prev_d;
  logic viol;

  // A granted requester must hold req through its run, and must have
  // released it by the cycle after its ack.
  always_comb begin
    viol = ((state_q == RUN_ST) && !bus.st_req) ||
           ((state_q == RUN_KW) && !bus.kw_req) ||
           (st_ack_prev_q && bus.st_req) ||
           (kw_ack_prev_q && bus.kw_req);
    err_d         = err_q | viol;
    st_ack_prev_d = bus.st_ack;
    kw_ack_prev_d = bus.kw_ack;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q         <= 1'b0;
      st_ack_prev_q <= 1'b0;
      kw_ack_prev_q <= 1'b0;
    end else begin
      err_q         <= err_d;
      st_ack_prev_q <= st_ack_prev_d;
      kw_ack_prev_q <= kw_ack_prev_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_sbox_share_sched.sv
// tb_sbox_share_sched
//   Directed bench for sbox_share_sched with an AES S-box model driving
//   sb_sub. Cycle k means "1 time unit after the rising edge that starts
//   cycle k"; a req set in cycle 0 is sampled on the edge ending cycle 0.
module tb_sbox_share_sched;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  sbox_share_sched_if bus ();

`ifdef SCHED_PROTO_CHK_EN
  logic err;
`endif

  sbox_share_sched #(.KEY_FIRST(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef SCHED_PROTO_CHK_EN
    ,
    .err (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  assign bus.sb_sub = sbox(bus.sb_byte);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  localparam logic [127:0] ST_INC     = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] ST_INC_SUB = 128'h76abd7fe2b670130c56f6bf27b777c63;
  localparam logic [127:0] ST_ZERO_SUB = {16{8'h63}};
  localparam logic [31:0]  KW_A       = 32'h00010253;
  localparam logic [31:0]  KW_A_SUB   = 32'h637c77ed;

  logic [1:0]  exp_grant [4];
  logic        seen;
  logic [7:0]  kw_bytes [4];

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.st_req = 1'b0;
    bus.st_in  = '0;
    bus.kw_req = 1'b0;
    bus.kw_in  = '0;
    kw_bytes[0] = 8'h53; kw_bytes[1] = 8'h02; kw_bytes[2] = 8'h01; kw_bytes[3] = 8'h00;
    exp_grant[0] = 2'b10; exp_grant[1] = 2'b01; exp_grant[2] = 2'b10; exp_grant[3] = 2'b01;

    // Reset state
    tick(); tick();
    chk("rst_busy",   {127'h0, bus.busy},   128'h0);
    chk("rst_grant",  {126'h0, bus.grant},  128'h0);
    chk("rst_st_out", bus.st_out,           128'h0);
    chk("rst_kw_out", {96'h0, bus.kw_out},  128'h0);
    chk("rst_acks",   {126'h0, bus.st_ack, bus.kw_ack}, 128'h0);
    chk("rst_sbbyte", {120'h0, bus.sb_byte}, 128'h0);
    rst = 1'b1;
    tick();

    // Key channel alone
    bus.kw_in  = KW_A;
    bus.kw_req = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk($sformatf("kw_sb_c%0d", c), {120'h0, bus.sb_byte}, {120'h0, kw_bytes[c-1]});
      chk($sformatf("kw_grant_c%0d", c), {126'h0, bus.grant}, 128'h2);
      chk($sformatf("kw_noack_c%0d", c), {127'h0, bus.kw_ack}, 128'h0);
    end
    tick();
    chk("kw_ack_c5",  {127'h0, bus.kw_ack}, 128'h1);
    chk("kw_out_c5",  {96'h0, bus.kw_out},  {96'h0, KW_A_SUB});
    chk("kw_sb_done", {120'h0, bus.sb_byte}, 128'h0);
    bus.kw_req = 1'b0;
    tick();
    chk("kw_idle_busy", {127'h0, bus.busy},   128'h0);
    chk("kw_idle_ack",  {127'h0, bus.kw_ack}, 128'h0);
    chk("kw_out_hold",  {96'h0, bus.kw_out},  {96'h0, KW_A_SUB});

    // State channel alone, incrementing bytes
    bus.st_in  = ST_INC;
    bus.st_req = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk($sformatf("st_sb_c%0d", c), {120'h0, bus.sb_byte}, 128'(c - 1));
      chk($sformatf("st_busy_c%0d", c), {127'h0, bus.busy}, 128'h1);
    end
    tick();
    chk("st_ack_c17",  {127'h0, bus.st_ack}, 128'h1);
    chk("st_out_c17",  bus.st_out, ST_INC_SUB);
    chk("st_busy_c17", {127'h0, bus.busy}, 128'h1);
    chk("st_grant_c17", {126'h0, bus.grant}, 128'h1);
    bus.st_req = 1'b0;
    tick();
    chk("st_idle_busy", {127'h0, bus.busy}, 128'h0);
    chk("st_out_hold",  bus.st_out, ST_INC_SUB);
    chk("kw_out_kept",  {96'h0, bus.kw_out}, {96'h0, KW_A_SUB});

    // Tie right after reset: key wins first
    rst = 1'b0; tick(); rst = 1'b1; tick();
    bus.st_in  = '0;
    bus.kw_in  = KW_A;
    bus.st_req = 1'b1;
    bus.kw_req = 1'b1;
    tick();
    chk("tie_grant_c1", {126'h0, bus.grant}, 128'h2);
    tick(); tick(); tick(); tick();
    chk("tie_kw_ack_c5", {127'h0, bus.kw_ack}, 128'h1);
    bus.kw_req = 1'b0;
    tick();
    chk("tie_idle_c6", {126'h0, bus.grant}, 128'h0);
    tick();
    chk("tie_st_grant_c7", {126'h0, bus.grant}, 128'h1);
    for (int c = 8; c <= 22; c++) tick();
    chk("tie_st_noack_c22", {127'h0, bus.st_ack}, 128'h0);
    tick();
    chk("tie_st_ack_c23", {127'h0, bus.st_ack}, 128'h1);
    chk("tie_st_out_c23", bus.st_out, ST_ZERO_SUB);
    bus.st_req = 1'b0;
    tick();

    // Alternation with both requesters re-raising after each ack
    rst = 1'b0; tick(); rst = 1'b1; tick();
    bus.st_req = 1'b1;
    bus.kw_req = 1'b1;
    for (int r = 0; r < 4; r++) begin
      tick();
      chk($sformatf("alt_grant_r%0d", r), {126'h0, bus.grant}, {126'h0, exp_grant[r]});
      if (r > 0) begin
        if (exp_grant[r-1] == 2'b10) bus.kw_req = 1'b1;
        else bus.st_req = 1'b1;
      end
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        tick();
        chk($sformatf("alt_ack_owner_r%0d", r),
            {126'h0, ({bus.kw_ack, bus.st_ack} & ~bus.grant)}, 128'h0);
        if (bus.st_ack || bus.kw_ack) seen = 1'b1;
      end
      chk($sformatf("alt_ack_which_r%0d", r), {126'h0, bus.kw_ack, bus.st_ack},
          {126'h0, exp_grant[r]});
      if (exp_grant[r] == 2'b10) begin
        chk($sformatf("alt_kw_out_r%0d", r), {96'h0, bus.kw_out}, {96'h0, KW_A_SUB});
        bus.kw_req = 1'b0;
      end else begin
        chk($sformatf("alt_st_out_r%0d", r), bus.st_out, ST_ZERO_SUB);
        bus.st_req = 1'b0;
      end
      tick();
      chk($sformatf("alt_idle_r%0d", r), {127'h0, bus.busy}, 128'h0);
    end
    bus.st_req = 1'b0;
    bus.kw_req = 1'b0;
    tick();

    // Reset in the middle of a state run
    bus.st_in  = ST_INC;
    bus.st_req = 1'b1;
    for (int c = 1; c <= 8; c++) tick();
    chk("mid_busy_before", {127'h0, bus.busy}, 128'h1);
    rst = 1'b0;
    #1;
    chk("mid_busy",   {127'h0, bus.busy},   128'h0);
    chk("mid_grant",  {126'h0, bus.grant},  128'h0);
    chk("mid_st_out", bus.st_out,           128'h0);
    chk("mid_sbbyte", {120'h0, bus.sb_byte}, 128'h0);
    bus.st_req = 1'b0;
    tick();
    tick();
    chk("mid_no_ack", {127'h0, bus.st_ack}, 128'h0);
    rst = 1'b1;
    tick();
    chk("mid_after_rel", {127'h0, bus.st_ack}, 128'h0);
    bus.st_in  = '0;
    bus.st_req = 1'b1;
    for (int c = 1; c <= 16; c++) tick();
    chk("fresh_noack_c16", {127'h0, bus.st_ack}, 128'h0);
    tick();
    chk("fresh_ack_c17", {127'h0, bus.st_ack}, 128'h1);
    chk("fresh_out_c17", bus.st_out, ST_ZERO_SUB);
    bus.st_req = 1'b0;
    tick();

`ifdef SCHED_PROTO_CHK_EN
    // Protocol checker: key req dropped mid-run
    rst = 1'b0; tick(); rst = 1'b1; tick();
    chk("err_rst", {127'h0, err}, 128'h0);
    bus.kw_in  = KW_A;
    bus.kw_req = 1'b1;
    tick();
    chk("err_c1", {127'h0, err}, 128'h0);
    tick();
    bus.kw_req = 1'b0;
    chk("err_c2", {127'h0, err}, 128'h0);
    tick();
    chk("err_c3", {127'h0, err}, 128'h1);
    tick(); tick();
    chk("err_kw_ack_c5", {127'h0, bus.kw_ack}, 128'h1);
    chk("err_kw_out_c5", {96'h0, bus.kw_out}, {96'h0, KW_A_SUB});
    tick(); tick(); tick();
    chk("err_sticky", {127'h0, err}, 128'h1);
    rst = 1'b0;
    #1;
    chk("err_cleared", {127'h0, err}, 128'h0);
    rst = 1'b1;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sbox_share_sched.md
Name: sbox_share_sched

Overview:
Scheduler that time-shares one external byte-wide combinational S-box between two requesters:
- the round datapath, which sends 16-byte SubBytes blocks;
- the key-expansion unit, which sends 4-byte SubWord words.
It arbitrates round-robin, captures the operand, serialises bytes LSB-first through the S-box, reassembles the result, and returns it with an ack pulse.

Parameters:
KEY_FIRST, 1, initial round-robin pointer after reset (1 = key channel wins first tie, 0 = state channel).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
st_req  input  1  state-channel request, level; hold until st_ack.
st_in  input  128  state operand, sampled on grant edge.
st_ack  output  1  one-cycle pulse, st_out valid.
st_out  output  128  substituted state; held until next state completion.
kw_req  input  1  key-word request, level; hold until kw_ack.
kw_in  input  32  key word operand, sampled on grant edge.
kw_ack  output  1  one-cycle pulse, kw_out valid.
kw_out  output  32  substituted word; held until next key completion.
sb_byte  output  8  byte presented to the external S-box.
sb_sub  input  8  S-box result for sb_byte, same cycle (combinational).
busy  output  1  high in RUN_ST, RUN_KW, DONE.
grant  output  2  one-hot owner: [0] state, [1] key; 0 in IDLE.

Behaviour:
- Reset (rst low, async): FSM=IDLE, byte counter=0, RR pointer=KEY_FIRST.
  - All outputs 0: st_out, kw_out, acks, busy, grant, sb_byte.
  - Internal operand/result registers are cleared.
- FSM states: IDLE, RUN_ST, RUN_KW, DONE.
- IDLE: requests sampled at the clock edge.
  - Only one req high: that channel wins.
  - Both high: the channel indicated by the RR pointer wins; pointer then flips to the other channel.
  - The winning operand is latched into the shift register. The counter clears.
  - Next state is RUN_ST or RUN_KW. No request: stay in IDLE.
- RUN_ST: 16 cycles, counter 0..15.
  - sb_byte = shift_reg[7:0].
  - sb_sub is written into result byte [8*cnt+7:8*cnt].
  - shift_reg shifts right 8 each cycle.
  - After cnt=15, go to DONE.
- RUN_KW: same as RUN_ST over 4 cycles, counter 0..3. Result is 32 bits.
- DONE: one cycle.
  - Result is copied to st_out or kw_out.
  - The matching ack = 1, grant still shows the owner.
  - Next state is IDLE.
- Latency, with req sampled at the end of cycle 0:
  - state: RUN cycles 1..16, ack in cycle 17;
  - key: RUN cycles 1..4, ack in cycle 5.
- Handshake: a requester must have req low in the cycle after ack, i.e. it drops req on the edge where it samples ack. Operands only need to be stable on the grant edge.
- Back-to-back: the cycle after DONE is always IDLE, so minimum spacing is 1 idle cycle. A pending other-channel req is granted at the end of that IDLE cycle.
- No preemption: a req arriving mid-RUN waits. Both channels held continuously alternate strictly.
- Outputs not being updated hold their value. sb_byte = 0 in IDLE and DONE.
- rst low mid-operation: the operation is abandoned immediately, no ack is issued, and outputs return to reset values. Requesters must re-request after rst rises.
- RR pointer changes only on a tie. A sole-requester grant leaves it unchanged.

Optional Feature:
Macro SCHED_PROTO_CHK_EN.
- Defined: adds output port err (1 bit, sticky). err is set on the edge after either event below, and cleared only by rst:
  - a channel's req falls while that channel is granted and not yet acked;
  - a channel's req is still high in the cycle after its ack.
  Scheduling is unaffected.
- Undefined: err port and its logic are absent; violations are not reported.

Test Plan:
- State channel alone, st_in = 128'h0 → sb_byte = 00 for 16 cycles; st_ack in cycle 17; st_out = {16{8'h63}}; busy high cycles 1..17.
- Key channel alone, kw_in = 32'h00010253 → sb_byte sequence 53, 02, 01, 00; kw_ack in cycle 5; kw_out = 32'h637c77ed.
- Both reqs high at cycle 0 after reset, KEY_FIRST = 1 → grant = 2'b10 first, kw_ack in cycle 5; state granted at end of cycle 6, st_ack in cycle 23.
- Both reqs re-raised after every ack, 4 rounds → grants alternate key, state, key, state; no ack is ever asserted for a non-granted channel.
- rst driven low in cycle 8 of a state run → busy, grant, st_out = 0 immediately; no st_ack; a fresh req after release completes normally with 17-cycle latency.
- With SCHED_PROTO_CHK_EN defined: drop kw_req in cycle 2 of RUN_KW → err = 1 from the next cycle; run completes with kw_ack; err stays 1 until rst.
